sha256_digest_reader: RTL

//   Reads out the final SHA-256 hash state (H0..H7 working registers) after a block completes.

---
 rtl/sha256_digest_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sha256_digest_reader.sv
// sha256_digest_reader
//   Snapshots the final SHA-256 hash state (H0..H7) when the core pulses
//   done_i, then streams the snapshot out big-endian as OUT_W-bit beats over
//   a valid/ready interface. The snapshot frees the core to start its next
//   block immediately.
//
//   Ports
//     CLK          system clock, rising edge
//     RST          asynchronous reset, active-low
//     done_i       one-cycle pulse: digest_i holds the final H0..H7
//     digest_i     {H0,H1,...,H7}, H0 in the MSBs
//     out_valid_o  out_data_o holds a valid beat
//     out_ready_i  sink accepts the beat this cycle
//     out_data_o   digest beat, most significant beat first
//     out_last_o   high with the final beat
//     busy_o       high while streaming
//     overrun_o    sticky: done_i arrived while busy and was dropped
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no snapshot pending, outputs quiet, waiting for done_i
//   SEND  | presenting snapshot beat cnt; advances on valid & ready
module sha256_digest_reader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int OUT_W     = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        done_i,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OUT_W-1:0]            out_data_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  localparam int W     = WORD_W * NUM_WORDS;
  localparam int BEATS = W / OUT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic               overrun_q, overrun_d;
  logic               xfer;
  logic [W-1:0]       shifted;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    xfer      = (state_q == SEND) && out_ready_i;

    case (state_q)
      IDLE: begin
        if (done_i) begin
          shadow_d = digest_i;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer && (cnt_q == LAST_CNT)) begin
          cnt_d = '0;
          // A digest landing on the final transfer chains straight into the
          // next stream, so the sink sees no bubble and nothing is lost.
          if (done_i) begin
            shadow_d = digest_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (done_i) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output beat is computed from next-state values so data/last are
    // registered alongside the state and stay put while the sink stalls.
    shifted = shadow_d << (int'(cnt_d) * OUT_W);
    data_d  = '0;
    if (state_d == SEND) begin
      data_d = shifted[W-1 -: OUT_W];
    end
    last_d = (state_d == SEND) && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid_o = (state_q == SEND);
  assign busy_o      = (state_q == SEND);
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign overrun_o   = overrun_q;

endmodule
